// File: rtl/afe_addr_gen_pkg.sv
// Shared definitions for the multi-channel AFE L2 address generator:
// default widths, the channel-select width helper and the per-channel state record.
package afe_addr_gen_pkg;

    localparam int ADDR_GEN_DATA_BYTES = 4;
    localparam int ADDR_GEN_AWIDTH     = 18;
    localparam int ADDR_GEN_TRANS_SIZE = 16;
    localparam int ADDR_GEN_WRAP_W     = 8;

    // Channel-select width; a single channel still needs a 1-bit select.
    function automatic int calc_ch_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // Channel state at the default widths; channels build the same record at their own widths.
    typedef struct packed {
        logic                           en;
        logic [ADDR_GEN_AWIDTH-1:0]     addr;
        logic [ADDR_GEN_TRANS_SIZE-1:0] left;
        logic [ADDR_GEN_WRAP_W-1:0]     wrap_cnt;
    } ch_state_t;

endpackage

// File: rtl/afe_l2_addr_gen_mc_ch.sv
// One channel of the L2 address generator: circular-buffer pointers, wrap counter
// and registered watermark/end/error pulses. Priority: clear > arm > transfer hit.
module afe_l2_addr_ch
    import afe_addr_gen_pkg::*;
#(
    parameter int AWIDTH     = ADDR_GEN_AWIDTH,
    parameter int TRANS_SIZE = ADDR_GEN_TRANS_SIZE,
    parameter int DATA_BYTES = ADDR_GEN_DATA_BYTES,
    parameter int WRAP_W     = ADDR_GEN_WRAP_W
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [AWIDTH-1:0]     cfg_startaddr_i,
    input  logic [TRANS_SIZE-1:0] cfg_size_i,
    input  logic [TRANS_SIZE-1:0] cfg_wm_i,
    input  logic                  cfg_continuous_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_clr_i,
    input  logic                  hit_i,
    output logic                  en_o,
    output logic [AWIDTH-1:0]     curr_addr_o,
    output logic [TRANS_SIZE-1:0] wr_ptr_o,
    output logic [TRANS_SIZE-1:0] bytes_left_o,
    output logic [WRAP_W-1:0]     wrap_cnt_o,
    output logic                  err_o,
    output logic                  wm_event_o,
    output logic                  end_event_o
);

    typedef struct packed {
        logic                  en;
        logic [AWIDTH-1:0]     addr;
        logic [TRANS_SIZE-1:0] left;
        logic [WRAP_W-1:0]     wrap_cnt;
    } state_t;

    localparam logic [AWIDTH-1:0]     STEP_A = AWIDTH'(DATA_BYTES);
    localparam logic [TRANS_SIZE-1:0] STEP_T = TRANS_SIZE'(DATA_BYTES);

    state_t                st_q, st_d;
    logic [TRANS_SIZE-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
    logic                  err_q, err_d;
    logic                  wm_q, wm_d;
    logic                  end_q, end_d;
    logic                  last;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        st_d       = st_q;
        wr_ptr_d   = wr_ptr_q;
        err_d      = 1'b0;
        wm_d       = 1'b0;
        end_d      = 1'b0;
        last       = (st_q.left <= STEP_T);
        wr_ptr_nxt = wr_ptr_q + STEP_T;

        if (cfg_clr_i) begin
            st_d     = '0;
            wr_ptr_d = '0;
        end else if (cfg_en_i && !st_q.en) begin
            if (cfg_size_i >= STEP_T) begin
                st_d.en       = 1'b1;
                st_d.addr     = cfg_startaddr_i;
                st_d.left     = cfg_size_i;
                st_d.wrap_cnt = '0;
                wr_ptr_d      = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (hit_i && st_q.en) begin
            if (last) begin
                end_d    = 1'b1;
                wr_ptr_d = '0;
                // A still-requested channel keeps running even in one-shot mode.
                if (cfg_continuous_i || cfg_en_i) begin
                    st_d.addr = cfg_startaddr_i;
                    st_d.left = cfg_size_i;
                    if (st_q.wrap_cnt != '1) begin
                        st_d.wrap_cnt = st_q.wrap_cnt + WRAP_W'(1);
                    end
                end else begin
                    st_d.en   = 1'b0;
                    st_d.addr = '0;
                    st_d.left = '0;
                end
            end else begin
                st_d.addr = st_q.addr + STEP_A;
                st_d.left = st_q.left - STEP_T;
                wr_ptr_d  = wr_ptr_nxt;
                wm_d      = (cfg_wm_i != '0) && (wr_ptr_nxt == cfg_wm_i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rstn_i) begin
            st_q     <= '0;
            wr_ptr_q <= '0;
            err_q    <= 1'b0;
            wm_q     <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            wr_ptr_q <= wr_ptr_d;
            err_q    <= err_d;
            wm_q     <= wm_d;
            end_q    <= end_d;
        end
    end

    assign en_o         = st_q.en;
    assign curr_addr_o  = st_q.addr;
    assign wr_ptr_o     = wr_ptr_q;
    assign bytes_left_o = st_q.left;
    assign wrap_cnt_o   = st_q.wrap_cnt;
    assign err_o        = err_q;
    assign wm_event_o   = wm_q;
    assign end_event_o  = end_q;

endmodule

// File: rtl/afe_l2_addr_gen_mc.sv
// Multi-channel L2 address generator for the AFE uDMA RX path: decodes the uDMA channel
// into a per-channel hit, muxes the selected write address and flags dropped transfers.
module afe_l2_addr_gen_mc
    import afe_addr_gen_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int AWIDTH     = ADDR_GEN_AWIDTH,
    parameter int TRANS_SIZE = ADDR_GEN_TRANS_SIZE,
    parameter int DATA_BYTES = ADDR_GEN_DATA_BYTES,
    parameter int WRAP_W     = ADDR_GEN_WRAP_W
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic [N_CH*AWIDTH-1:0]       cfg_startaddr_i,
    input  logic [N_CH*TRANS_SIZE-1:0]   cfg_size_i,
    input  logic [N_CH*TRANS_SIZE-1:0]   cfg_wm_i,
    input  logic [N_CH-1:0]              cfg_continuous_i,
    input  logic [N_CH-1:0]              cfg_en_i,
    input  logic [N_CH-1:0]              cfg_clr_i,
    output logic [N_CH-1:0]              cfg_en_o,
    output logic [N_CH*AWIDTH-1:0]       cfg_curr_addr_o,
    output logic [N_CH*TRANS_SIZE-1:0]   cfg_wr_ptr_o,
    output logic [N_CH*TRANS_SIZE-1:0]   cfg_bytes_left_o,
    output logic [N_CH*WRAP_W-1:0]       cfg_wrap_cnt_o,
    output logic [N_CH-1:0]              cfg_err_o,
    output logic [N_CH-1:0]              ch_wm_event_o,
    output logic [N_CH-1:0]              ch_end_event_o,
    input  logic                         udma_vtransfer_i,
    input  logic [calc_ch_w(N_CH)-1:0]   udma_ch_i,
    output logic [AWIDTH-1:0]            udma_addr_o,
    output logic                         udma_drop_o
);

    localparam int CH_W = calc_ch_w(N_CH);

    logic [N_CH-1:0]   hit_vec;
    logic [AWIDTH-1:0] addr_mux;
    logic              drop_q, drop_d;

    // A transfer counts only on an active channel that is not being cleared;
    // anything else, including an out-of-range channel number, is a drop.
    always_comb begin
        hit_vec  = '0;
        addr_mux = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (udma_ch_i == CH_W'(c)) begin
                addr_mux   = cfg_curr_addr_o[c*AWIDTH +: AWIDTH];
                hit_vec[c] = udma_vtransfer_i && cfg_en_o[c] && !cfg_clr_i[c];
            end
        end
        drop_d = udma_vtransfer_i && !(|hit_vec);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign udma_addr_o = addr_mux;
    assign udma_drop_o = drop_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        afe_l2_addr_ch #(
            .AWIDTH     (AWIDTH),
            .TRANS_SIZE (TRANS_SIZE),
            .DATA_BYTES (DATA_BYTES),
            .WRAP_W     (WRAP_W)
        ) u_ch (
            .clk_i            (clk_i),
            .rstn_i           (rstn_i),
            .cfg_startaddr_i  (cfg_startaddr_i[c*AWIDTH +: AWIDTH]),
            .cfg_size_i       (cfg_size_i[c*TRANS_SIZE +: TRANS_SIZE]),
            .cfg_wm_i         (cfg_wm_i[c*TRANS_SIZE +: TRANS_SIZE]),
            .cfg_continuous_i (cfg_continuous_i[c]),
            .cfg_en_i         (cfg_en_i[c]),
            .cfg_clr_i        (cfg_clr_i[c]),
            .hit_i            (hit_vec[c]),
            .en_o             (cfg_en_o[c]),
            .curr_addr_o      (cfg_curr_addr_o[c*AWIDTH +: AWIDTH]),
            .wr_ptr_o         (cfg_wr_ptr_o[c*TRANS_SIZE +: TRANS_SIZE]),
            .bytes_left_o     (cfg_bytes_left_o[c*TRANS_SIZE +: TRANS_SIZE]),
            .wrap_cnt_o       (cfg_wrap_cnt_o[c*WRAP_W +: WRAP_W]),
            .err_o            (cfg_err_o[c]),
            .wm_event_o       (ch_wm_event_o[c]),
            .end_event_o      (ch_end_event_o[c])
        );
    end

endmodule

// File: tb/tb_afe_l2_addr_gen_mc.sv
// Directed bench for afe_l2_addr_gen_mc: per-transfer expectations go through a
// scoreboard queue and are compared once the registered pulses appear.
module tb_afe_l2_addr_gen_mc;

    localparam int N  = 4;
    localparam int AW = 18;
    localparam int TS = 16;
    localparam int DB = 4;
    localparam int WW = 2;

    logic              clk_i;
    logic              rstn_i;
    logic [N*AW-1:0]   cfg_startaddr_i;
    logic [N*TS-1:0]   cfg_size_i;
    logic [N*TS-1:0]   cfg_wm_i;
    logic [N-1:0]      cfg_continuous_i;
    logic [N-1:0]      cfg_en_i;
    logic [N-1:0]      cfg_clr_i;
    logic [N-1:0]      cfg_en_o;
    logic [N*AW-1:0]   cfg_curr_addr_o;
    logic [N*TS-1:0]   cfg_wr_ptr_o;
    logic [N*TS-1:0]   cfg_bytes_left_o;
    logic [N*WW-1:0]   cfg_wrap_cnt_o;
    logic [N-1:0]      cfg_err_o;
    logic [N-1:0]      ch_wm_event_o;
    logic [N-1:0]      ch_end_event_o;
    logic              udma_vtransfer_i;
    logic [1:0]        udma_ch_i;
    logic [AW-1:0]     udma_addr_o;
    logic              udma_drop_o;

    typedef struct {
        string      tag;
        logic       drop;
        logic [3:0] wm;
        logic [3:0] endv;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    afe_l2_addr_gen_mc #(
        .N_CH       (N),
        .AWIDTH     (AW),
        .TRANS_SIZE (TS),
        .DATA_BYTES (DB),
        .WRAP_W     (WW)
    ) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .cfg_startaddr_i  (cfg_startaddr_i),
        .cfg_size_i       (cfg_size_i),
        .cfg_wm_i         (cfg_wm_i),
        .cfg_continuous_i (cfg_continuous_i),
        .cfg_en_i         (cfg_en_i),
        .cfg_clr_i        (cfg_clr_i),
        .cfg_en_o         (cfg_en_o),
        .cfg_curr_addr_o  (cfg_curr_addr_o),
        .cfg_wr_ptr_o     (cfg_wr_ptr_o),
        .cfg_bytes_left_o (cfg_bytes_left_o),
        .cfg_wrap_cnt_o   (cfg_wrap_cnt_o),
        .cfg_err_o        (cfg_err_o),
        .ch_wm_event_o    (ch_wm_event_o),
        .ch_end_event_o   (ch_end_event_o),
        .udma_vtransfer_i (udma_vtransfer_i),
        .udma_ch_i        (udma_ch_i),
        .udma_addr_o      (udma_addr_o),
        .udma_drop_o      (udma_drop_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int c);
        return cfg_curr_addr_o[c*AW +: AW];
    endfunction

    function automatic logic [TS-1:0] left_of(input int c);
        return cfg_bytes_left_o[c*TS +: TS];
    endfunction

    function automatic logic [TS-1:0] wrp_of(input int c);
        return cfg_wr_ptr_o[c*TS +: TS];
    endfunction

    function automatic logic [WW-1:0] wrap_of(input int c);
        return cfg_wrap_cnt_o[c*WW +: WW];
    endfunction

    task automatic set_cfg(input int c, input logic [AW-1:0] start, input logic [TS-1:0] size,
                           input logic [TS-1:0] wm, input logic cont);
        cfg_startaddr_i[c*AW +: AW] = start;
        cfg_size_i[c*TS +: TS]      = size;
        cfg_wm_i[c*TS +: TS]        = wm;
        cfg_continuous_i[c]         = cont;
    endtask

    task automatic arm(input int c, input logic exp_err, input string tag);
        logic [3:0] err_exp;
        err_exp = exp_err ? (4'b0001 << c) : 4'b0000;
        @(negedge clk_i);
        cfg_en_i[c] = 1'b1;
        @(posedge clk_i);
        #1;
        cfg_en_i[c] = 1'b0;
        check({tag, ".err"}, cfg_err_o, err_exp);
        check({tag, ".en"}, cfg_en_o[c], !exp_err);
    endtask

    task automatic clr(input int c, input string tag);
        @(negedge clk_i);
        cfg_clr_i[c] = 1'b1;
        @(posedge clk_i);
        #1;
        cfg_clr_i[c] = 1'b0;
        check({tag, ".en"}, cfg_en_o[c], 1'b0);
    endtask

    task automatic hit(input int ch, input logic [3:0] clr_mask, input logic [AW-1:0] exp_addr,
                       input logic [3:0] exp_wm, input logic [3:0] exp_end, input logic exp_drop,
                       input string tag);
        exp_t e;
        @(negedge clk_i);
        udma_vtransfer_i = 1'b1;
        udma_ch_i        = 2'(ch);
        cfg_clr_i        = clr_mask;
        #1;
        check({tag, ".addr"}, udma_addr_o, exp_addr);
        e.tag  = tag;
        e.drop = exp_drop;
        e.wm   = exp_wm;
        e.endv = exp_end;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        udma_vtransfer_i = 1'b0;
        cfg_clr_i        = '0;
        e = sb.pop_front();
        check({e.tag, ".drop"}, udma_drop_o, e.drop);
        check({e.tag, ".wm"}, ch_wm_event_o, e.wm);
        check({e.tag, ".end"}, ch_end_event_o, e.endv);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".en"}, cfg_en_o, '0);
        check({tag, ".addr"}, cfg_curr_addr_o, '0);
        check({tag, ".wrptr"}, cfg_wr_ptr_o, '0);
        check({tag, ".left"}, cfg_bytes_left_o, '0);
        check({tag, ".wrap"}, cfg_wrap_cnt_o, '0);
        check({tag, ".err"}, cfg_err_o, '0);
        check({tag, ".wm"}, ch_wm_event_o, '0);
        check({tag, ".end"}, ch_end_event_o, '0);
        check({tag, ".drop"}, udma_drop_o, 1'b0);
        check({tag, ".uaddr"}, udma_addr_o, '0);
    endtask

    initial begin
        rstn_i           = 1'b0;
        cfg_startaddr_i  = '0;
        cfg_size_i       = '0;
        cfg_wm_i         = '0;
        cfg_continuous_i = '0;
        cfg_en_i         = '0;
        cfg_clr_i        = '0;
        udma_vtransfer_i = 1'b0;
        udma_ch_i        = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check_zero("reset");
        @(negedge clk_i);
        rstn_i = 1'b1;

        // 1: one-shot buffer, four transfers, stops at the end.
        set_cfg(0, 18'h00100, 16'd16, 16'd0, 1'b0);
        arm(0, 1'b0, "t1_arm");
        check("t1_addr0", addr_of(0), 18'h00100);
        check("t1_left0", left_of(0), 16'd16);
        hit(0, 4'b0000, 18'h00100, 4'b0000, 4'b0000, 1'b0, "t1_h1");
        hit(0, 4'b0000, 18'h00104, 4'b0000, 4'b0000, 1'b0, "t1_h2");
        check("t1_wrptr", wrp_of(0), 16'd8);
        check("t1_left", left_of(0), 16'd8);
        hit(0, 4'b0000, 18'h00108, 4'b0000, 4'b0000, 1'b0, "t1_h3");
        hit(0, 4'b0000, 18'h0010C, 4'b0000, 4'b0001, 1'b0, "t1_h4");
        check("t1_en_off", cfg_en_o[0], 1'b0);
        check("t1_addr_off", addr_of(0), 18'h0);
        check("t1_left_off", left_of(0), 16'd0);

        // 2: continuous buffer with watermark at 8 bytes, two full passes.
        set_cfg(1, 18'h02000, 16'd16, 16'd8, 1'b1);
        arm(1, 1'b0, "t2_arm");
        hit(1, 4'b0000, 18'h02000, 4'b0000, 4'b0000, 1'b0, "t2_h1");
        hit(1, 4'b0000, 18'h02004, 4'b0010, 4'b0000, 1'b0, "t2_h2");
        hit(1, 4'b0000, 18'h02008, 4'b0000, 4'b0000, 1'b0, "t2_h3");
        hit(1, 4'b0000, 18'h0200C, 4'b0000, 4'b0010, 1'b0, "t2_h4");
        check("t2_wrap1", wrap_of(1), 2'd1);
        hit(1, 4'b0000, 18'h02000, 4'b0000, 4'b0000, 1'b0, "t2_h5");
        hit(1, 4'b0000, 18'h02004, 4'b0010, 4'b0000, 1'b0, "t2_h6");
        hit(1, 4'b0000, 18'h02008, 4'b0000, 4'b0000, 1'b0, "t2_h7");
        hit(1, 4'b0000, 18'h0200C, 4'b0000, 4'b0010, 1'b0, "t2_h8");
        check("t2_wrap2", wrap_of(1), 2'd2);
        check("t2_addr", addr_of(1), 18'h02000);
        check("t2_en", cfg_en_o[1], 1'b1);
        check("t2_left", left_of(1), 16'd16);

        // 3: interleaved channels; ch2 wraps around the top of the address space.
        set_cfg(0, 18'h00300, 16'd64, 16'd0, 1'b0);
        arm(0, 1'b0, "t3_arm0");
        set_cfg(2, 18'h3FFF8, 16'd16, 16'd0, 1'b0);
        arm(2, 1'b0, "t3_arm2");
        set_cfg(3, 18'h01000, 16'd32, 16'd0, 1'b0);
        arm(3, 1'b0, "t3_arm3");
        hit(0, 4'b0000, 18'h00300, 4'b0000, 4'b0000, 1'b0, "t3_a");
        hit(2, 4'b0000, 18'h3FFF8, 4'b0000, 4'b0000, 1'b0, "t3_b");
        hit(1, 4'b0000, 18'h02000, 4'b0000, 4'b0000, 1'b0, "t3_c");
        hit(3, 4'b0000, 18'h01000, 4'b0000, 4'b0000, 1'b0, "t3_d");
        hit(2, 4'b0000, 18'h3FFFC, 4'b0000, 4'b0000, 1'b0, "t3_e");
        hit(0, 4'b0000, 18'h00304, 4'b0000, 4'b0000, 1'b0, "t3_f");
        hit(2, 4'b0000, 18'h00000, 4'b0000, 4'b0000, 1'b0, "t3_g");
        hit(3, 4'b0000, 18'h01004, 4'b0000, 4'b0000, 1'b0, "t3_h");
        check("t3_addr0", addr_of(0), 18'h00308);
        check("t3_addr1", addr_of(1), 18'h02004);
        check("t3_addr2", addr_of(2), 18'h00004);
        check("t3_addr3", addr_of(3), 18'h01008);
        check("t3_wrptr2", wrp_of(2), 16'd12);
        check("t3_en", cfg_en_o, 4'b1111);

        // 4: clear beats a same-cycle hit; hits to an inactive channel are dropped.
        hit(2, 4'b0100, 18'h00004, 4'b0000, 4'b0000, 1'b1, "t4_clrhit");
        check("t4_en2", cfg_en_o[2], 1'b0);
        check("t4_addr2", addr_of(2), 18'h0);
        check("t4_left2", left_of(2), 16'd0);
        check("t4_addr3_kept", addr_of(3), 18'h01008);
        clr(3, "t4_clr3");
        hit(3, 4'b0000, 18'h00000, 4'b0000, 4'b0000, 1'b1, "t4_dead");
        check("t4_en", cfg_en_o, 4'b0011);
        check("t4_addr3", addr_of(3), 18'h0);
        check("t4_addr0_kept", addr_of(0), 18'h00308);

        // 5: undersized arm is rejected; a 10-byte buffer takes three transfers.
        set_cfg(2, 18'h00500, 16'd2, 16'd0, 1'b0);
        arm(2, 1'b1, "t5_small");
        @(posedge clk_i);
        #1;
        check("t5_err_pulse", cfg_err_o, 4'b0000);
        set_cfg(2, 18'h00500, 16'd10, 16'd0, 1'b0);
        arm(2, 1'b0, "t5_arm");
        hit(2, 4'b0000, 18'h00500, 4'b0000, 4'b0000, 1'b0, "t5_h1");
        hit(2, 4'b0000, 18'h00504, 4'b0000, 4'b0000, 1'b0, "t5_h2");
        check("t5_left", left_of(2), 16'd2);
        hit(2, 4'b0000, 18'h00508, 4'b0000, 4'b0100, 1'b0, "t5_h3");
        check("t5_en2", cfg_en_o[2], 1'b0);

        // 6: reset mid-buffer, then drive the 2-bit wrap counter into saturation.
        @(negedge clk_i);
        rstn_i = 1'b0;
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        check_zero("t6_reset");
        set_cfg(1, 18'h00040, 16'd4, 16'd0, 1'b1);
        arm(1, 1'b0, "t6_arm");
        hit(1, 4'b0000, 18'h00040, 4'b0000, 4'b0010, 1'b0, "t6_h1");
        hit(1, 4'b0000, 18'h00040, 4'b0000, 4'b0010, 1'b0, "t6_h2");
        hit(1, 4'b0000, 18'h00040, 4'b0000, 4'b0010, 1'b0, "t6_h3");
        check("t6_wrap3", wrap_of(1), 2'd3);
        hit(1, 4'b0000, 18'h00040, 4'b0000, 4'b0010, 1'b0, "t6_h4");
        hit(1, 4'b0000, 18'h00040, 4'b0000, 4'b0010, 1'b0, "t6_h5");
        check("t6_wrap_sat", wrap_of(1), 2'd3);
        check("t6_en", cfg_en_o[1], 1'b1);
        check("t6_addr", addr_of(1), 18'h00040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
